// File: rtl/mvm_row_scheduler.sv
// ============================================================================
// mvm_row_scheduler: streams R weight rows through one S-wide dot-product
// unit and collects the per-row results. Optional macro: MVM_SCHED_BIAS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mvm_row_scheduler #(
  parameter int N = 8,
  parameter int S = 4,
  parameter int R = 4,
  localparam int AW = (R > 1) ? $clog2(R) : 1
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            start,
  input  logic [S*N-1:0]  u,
  input  logic [R*N-1:0]  bias,
  output logic            busy,
  output logic            done,
  output logic [R*N-1:0]  v_out,
  output logic            w_ren,
  output logic [AW-1:0]   w_addr,
  input  logic [S*N-1:0]  w_rdata,
  output logic [S*N-1:0]  mvm_w,
  output logic [S*N-1:0]  mvm_u,
  input  logic [N-1:0]    mvm_v
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [AW-1:0] LAST_ROW = AW'(R - 1);

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           s1_vld_q, s2_vld_q;
  logic [AW-1:0]  s1_row_q, s2_row_q;
  logic [S*N-1:0] u_q;
  logic [R*N-1:0] v_out_q;
  logic           done_q;
  logic [N-1:0]   wr_val;

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN ends once only the last row remains in stage 2
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (addr_q == LAST_ROW) state_d = ST_DRAIN;
      ST_DRAIN: if (s2_vld_q && !s1_vld_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state_q != ST_IDLE);
    w_ren  = (state_q == ST_ISSUE);
    done   = done_q;
    w_addr = addr_q;
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == ST_IDLE && start) begin
      addr_d = '0;
    end else if (state_q == ST_ISSUE && addr_q != LAST_ROW) begin
      addr_d = addr_q + 1'b1;
    end
  end

  assign mvm_w = w_rdata;
  assign mvm_u = u_q;
  assign v_out = v_out_q;

`ifdef MVM_SCHED_BIAS_EN
  logic [R*N-1:0] bias_q;
  logic [N:0]     bias_sum;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bias_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      bias_q <= bias;
    end
  end

  assign bias_sum = {1'b0, mvm_v} + {1'b0, bias_q[s2_row_q*N +: N]};
  assign wr_val   = bias_sum[N] ? {N{1'b1}} : bias_sum[N-1:0];
`else
  logic unused_bias;
  assign unused_bias = ^bias;
  assign wr_val      = mvm_v;
`endif

  // Tag pipeline: stage 1 = row on w_rdata, stage 2 = row result on mvm_v
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_row_q <= '0;
      s2_vld_q <= 1'b0;
      s2_row_q <= '0;
      u_q      <= '0;
      v_out_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      s1_vld_q <= w_ren;
      s1_row_q <= addr_q;
      s2_vld_q <= s1_vld_q;
      s2_row_q <= s1_row_q;
      done_q   <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      if (state_q == ST_IDLE && start) begin
        u_q <= u;
      end
      if (s2_vld_q) begin
        v_out_q[s2_row_q*N +: N] <= wr_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mvm_row_scheduler.sv
// ============================================================================
// tb_mvm_row_scheduler: self-checking bench with weight memory and
// saturating dot-product models. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mvm_row_scheduler;

  localparam int N = 8;
  localparam int S = 4;
  localparam int R = 4;
  localparam int AW = 2;

  logic           CLOCK_50 = 1'b0;
  logic           reset_n;
  logic           start;
  logic [S*N-1:0] u_i;
  logic [R*N-1:0] bias_i;
  logic           busy, done, w_ren;
  logic [R*N-1:0] v_out;
  logic [AW-1:0]  w_addr;
  logic [S*N-1:0] w_rdata = '0;
  logic [S*N-1:0] mvm_w, mvm_u;
  logic [N-1:0]   mvm_v;

  mvm_row_scheduler #(.N(N), .S(S), .R(R)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .start    (start),
    .u        (u_i),
    .bias     (bias_i),
    .busy     (busy),
    .done     (done),
    .v_out    (v_out),
    .w_ren    (w_ren),
    .w_addr   (w_addr),
    .w_rdata  (w_rdata),
    .mvm_w    (mvm_w),
    .mvm_u    (mvm_u),
    .mvm_v    (mvm_v)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Weight memory (read latency 1) and datapath (registered inputs)
  logic [S*N-1:0] mem [R];
  logic [S*N-1:0] dp_w = '0;
  logic [S*N-1:0] dp_u = '0;
  int             acc;

  always @(posedge CLOCK_50) begin
    if (w_ren) w_rdata <= mem[w_addr];
    dp_w <= mvm_w;
    dp_u <= mvm_u;
  end

  always_comb begin
    acc = 0;
    for (int i = 0; i < S; i++) acc += int'(dp_w[i*N +: N]) * int'(dp_u[i*N +: N]);
    mvm_v = (acc > 255) ? 8'hFF : acc[7:0];
  end

  int done_cnt = 0;
  always @(negedge CLOCK_50) if (done === 1'b1) done_cnt++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic load_mem(input logic [R*S*N-1:0] w);
    for (int r = 0; r < R; r++) mem[r] = w[r*S*N +: S*N];
  endtask

  // Called at #1 after an edge; returns cycles from accept edge to done
  task automatic run_one(input logic [S*N-1:0] uv, output int cyc, output int bc);
    u_i = uv;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    cyc = 0;
    bc = 0;
    while (!done && cyc < 30) begin
      if (busy) bc++;
      @(posedge CLOCK_50); #1;
      cyc++;
    end
  endtask

  typedef struct {
    logic [R*S*N-1:0] w;
    logic [S*N-1:0]   u;
    logic [R*N-1:0]   exp;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int cyc, bc, d0;
    logic [R*N-1:0] old;

    tbl[0].w   = {p4(0,0,0,0), p4(0,2,0,0), p4(1,0,0,0), p4(1,1,1,1)};
    tbl[0].u   = p4(1,2,3,4);
    tbl[0].exp = p4(10,1,4,0);
    tbl[1].w   = {p4(10,10,10,10), p4(0,0,2,2), p4(0,1,0,0), p4(255,0,0,0)};
    tbl[1].u   = p4(2,3,5,7);
    tbl[1].exp = p4(255,3,24,170);
    tbl[2].w   = {p4(255,255,255,255), p4(0,0,100,100), p4(1,2,3,4), p4(16,16,0,0)};
    tbl[2].u   = p4(8,8,1,1);
    tbl[2].exp = p4(255,31,200,255);

    reset_n = 1'b0;
    start   = 1'b0;
    u_i     = '0;
    bias_i  = '0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_w_ren", 128'(w_ren), 128'(0));
    chk("rst_w_addr", 128'(w_addr), 128'(0));
    chk("rst_v_out", 128'(v_out), 128'(0));
    chk("rst_mvm_u", 128'(mvm_u), 128'(0));
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;

    for (int i = 0; i < 3; i++) begin
      load_mem(tbl[i].w);
      run_one(tbl[i].u, cyc, bc);
      chk($sformatf("vec%0d_latency", i), 128'(cyc), 128'(R + 2));
      chk($sformatf("vec%0d_busy_cycles", i), 128'(bc), 128'(R + 2));
      chk($sformatf("vec%0d_busy_in_done", i), 128'(busy), 128'(0));
      chk($sformatf("vec%0d_v_out", i), 128'(v_out), 128'(tbl[i].exp));
    end

    // Back-to-back: start during the done cycle of the previous product
    old = v_out;
    load_mem(tbl[0].w);
    u_i = tbl[0].u;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    chk("b2b_accept_busy", 128'(busy), 128'(1));
    cyc = 0;
    while (!done && cyc < 30) begin
      @(posedge CLOCK_50); #1;
      cyc++;
      if (cyc == 2) chk("b2b_hold_all", 128'(v_out), 128'(old));
      if (cyc == 3) chk("b2b_row0_only", 128'(v_out),
                        128'({old[R*N-1:N], tbl[0].exp[N-1:0]}));
    end
    chk("b2b_latency", 128'(cyc), 128'(R + 2));
    chk("b2b_v_out", 128'(v_out), 128'(tbl[0].exp));

    // start pulsed mid-ISSUE is ignored
    @(posedge CLOCK_50); #1;
    load_mem(tbl[1].w);
    d0 = done_cnt;
    u_i = tbl[1].u;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    u_i = tbl[0].u;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 30) begin
      @(posedge CLOCK_50); #1;
      cyc++;
    end
    chk("busy_start_latency", 128'(cyc), 128'(R + 2));
    repeat (8) @(posedge CLOCK_50);
    #1;
    chk("busy_start_one_done", 128'(done_cnt - d0), 128'(1));
    chk("busy_start_idle", 128'(busy), 128'(0));
    chk("busy_start_v_out", 128'(v_out), 128'(tbl[1].exp));

    // Reset three cycles after accept
    load_mem(tbl[0].w);
    d0 = done_cnt;
    u_i = tbl[0].u;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_v_out", 128'(v_out), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_w_ren", 128'(w_ren), 128'(0));
    chk("midrst_mvm_u", 128'(mvm_u), 128'(0));
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1;
    chk("midrst_no_done", 128'(done_cnt - d0), 128'(0));
    chk("midrst_still_idle", 128'(busy), 128'(0));
    load_mem(tbl[2].w);
    run_one(tbl[2].u, cyc, bc);
    chk("postrst_latency", 128'(cyc), 128'(R + 2));
    chk("postrst_v_out", 128'(v_out), 128'(tbl[2].exp));

`ifdef MVM_SCHED_BIAS_EN
    @(posedge CLOCK_50); #1;
    load_mem({p4(0,0,0,0), p4(0,0,0,0), p4(10,0,0,0), p4(250,0,0,0)});
    bias_i = p4(10,5,0,0);
    run_one(p4(1,0,0,0), cyc, bc);
    bias_i = '0;
    chk("bias_latency", 128'(cyc), 128'(R + 2));
    chk("bias_sat_row0", 128'(v_out[N-1:0]), 128'(255));
    chk("bias_add_row1", 128'(v_out[2*N-1:N]), 128'(15));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mvm_row_scheduler.md
# mvm_row_scheduler

Sequencer that computes a full R×S matrix-vector product by streaming matrix rows from a weight memory through a single S-wide saturating dot-product unit, one row per cycle, and collecting the R per-row results into an output register bank. It sits between the gate-level LSTM control and the shared dot-product datapath, which has a one-cycle registered input stage and a combinational output. It owns the weight-memory read port and the datapath inputs.

## Interface
- N, 8, element width (unsigned)
- S, 4, elements per row / vector length
- R, 4, matrix rows (R ≥ 1); AW = $clog2(R) (minimum 1)

- CLOCK_50  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a new product; sampled only in IDLE
- u  in  S*N  input vector, captured on the start-accept edge
- bias  in  R*N  per-row bias, captured with u (used only under MVM_SCHED_BIAS_EN)
- busy  out  1  high from start-accept until done
- done  out  1  one-cycle pulse: v_out complete
- v_out  out  R*N  results; row r at [(r+1)*N-1 -: N]; held until the next done
- w_ren  out  1  weight-memory read enable
- w_addr  out  AW  row address
- w_rdata  in  S*N  row data, valid the cycle after w_ren
- mvm_w  out  S*N  datapath weight operand, equal to w_rdata (combinational)
- mvm_u  out  S*N  datapath vector operand, the registered u copy
- mvm_v  in  N  datapath result, valid the cycle after the operands are captured

## Operation
- FSM: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: busy=0, w_ren=0. When start=1: latch u and bias, w_addr←0, w_ren←1, enter ISSUE.
- ISSUE: one row address per cycle. Once w_addr=R-1 has issued, w_ren←0 and enter DRAIN.
- DRAIN: wait for the last two pipeline tags to retire, then enter IDLE, pulse done, busy←0.
- Two-stage tag pipeline {valid, row} tracks each row:
  - stage 1: data is on w_rdata / mvm_w.
  - stage 2: mvm_v is valid. On the next edge it is written into v_out[row].
- Result write: v_out[row] ← mvm_v, with no extra arithmetic in the base build.
- v_out rows are written in order 0..R-1. Rows not yet rewritten keep their previous values while busy.
- start while busy: ignored, no queuing.
- start in the done cycle: the FSM is already in IDLE, so start is accepted (back-to-back operation).
- R=1: ISSUE lasts one cycle, then DRAIN.
- Reset mid-operation clears everything, and the aborted product never raises done.
- Reset values: busy=0, done=0, w_ren=0, w_addr=0, v_out=0, tags invalid, u/bias registers=0.

## Timing
- Edge E0 accepts start.
- Between Ek and Ek+1 (k=0..R-1): w_addr=k, w_ren=1.
- After Ek+1: w_rdata = row k. The datapath captures it at Ek+2, and mvm_v is valid after Ek+2.
- v_out[k] is written at Ek+3.
- done=1 and busy=0 during the cycle after E(R+2).
- Latency: R+2 cycles from accept to done. Throughput: one row per cycle.
- mvm_u is stable for the whole operation.
- mvm_w is a pure wire, so the weight memory must meet its read latency of exactly 1.

## Configuration
- MVM_SCHED_BIAS_EN defined:
  - the write becomes v_out[row] ← sat_add(mvm_v, bias_reg[row]);
  - the (N+1)-bit sum clamps to 2^N−1 on carry-out;
  - the adder is registered-path combinational, so latency is unchanged.
- Undefined:
  - the bias port is present but ignored;
  - the bias registers are removed;
  - v_out[row] = mvm_v.

## Test plan
Bench uses N=8, S=4, R=4 and a behavioural saturating dot-product model for the datapath.
- Identity-like:
  - stimulus: rows {1,1,1,1},{1,0,0,0},{0,2,0,0},{0,0,0,0}; u={1,2,3,4};
  - required: v_out={10,1,4,0}; done exactly 6 cycles after the accept edge; busy high for 6 cycles.
- Saturation:
  - stimulus: row0={255,0,0,0} with u0=2;
  - required: v_out[0]=255.
- Back-to-back:
  - stimulus: assert start in the done cycle, with a new u;
  - required: second product accepted immediately; done after a further 6 cycles; the first v_out is held until it is overwritten row by row.
- start while busy:
  - stimulus: pulse start mid-ISSUE;
  - required: no effect; exactly one done; result matches the first u.
- Reset mid-operation:
  - stimulus: drop reset_n 3 cycles after accept, then release;
  - required: v_out=0, busy=0, done never pulses; a next start completes normally.
- Under MVM_SCHED_BIAS_EN:
  - stimulus: row result 250 with bias 10;
  - required: v_out=255.
  - stimulus: row result 10 with bias 5;
  - required: v_out=15.
